// File: rtl/cnt_snapshot_fifo.sv
// -----------------------------------------------------------------------------
// cnt_snapshot_fifo
//   Captures snapshots of a free-running wrap-at-WRAP_VAL counter into a small
//   show-ahead FIFO. Each entry is tagged with a wrap-epoch bit, so a consumer
//   can check that counter values arrive in order across wraps. Requests that
//   arrive while the FIFO is full (and nothing is popped) are dropped and
//   counted in a saturating counter.
//
// Ports
//   clk        rising-edge clock
//   rstf       asynchronous active-low reset
//   cnt_in     upstream counter value, sampled every cycle
//   sample_req capture request for this cycle
//   out_valid  head entry available (== !empty)
//   out_ready  consumer accepts the head entry (ignored while empty)
//   out_data   {epoch, count} of the head entry, 0 while empty
//   level      number of occupied entries
//   full       level == DEPTH
//   empty      level == 0
//   drop_cnt   saturating count of dropped requests
// -----------------------------------------------------------------------------
module cnt_snapshot_fifo #(
    parameter int CNT_W    = 6,
    parameter int WRAP_VAL = 15,
    parameter int DEPTH    = 4,
    parameter int DROP_W   = 8
) (
    input  logic                       clk,
    input  logic                       rstf,
    input  logic [CNT_W-1:0]           cnt_in,
    input  logic                       sample_req,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W:0]             out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [CNT_W:0]     mem_r [DEPTH];
    logic [CNT_W-1:0]   prev_cnt_r;
    logic               epoch_r;
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [LW-1:0]      level_r;
    logic [LW-1:0]      level_nxt_s;
    logic [DROP_W-1:0]  drop_cnt_r;
    logic [DROP_W-1:0]  drop_nxt_s;

    logic               wrap_now_s;
    logic               cur_epoch_s;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;
    logic [CNT_W:0]     head_s;

    // A wrap is the registered WRAP_VAL followed by a 0 on the live input.
    assign wrap_now_s  = (prev_cnt_r == CNT_W'(WRAP_VAL)) && (cnt_in == {CNT_W{1'b0}});
    // Captures in the wrap cycle already carry the new epoch.
    assign cur_epoch_s = epoch_r ^ wrap_now_s;

    assign full_s  = (level_r == LW'(DEPTH));
    assign empty_s = (level_r == {LW{1'b0}});

    // A full FIFO still accepts a request when the head leaves in the same cycle.
    assign pop_s  = !empty_s && out_ready;
    assign push_s = sample_req && (!full_s || pop_s);
    assign drop_s = sample_req && full_s && !pop_s;

    // Occupancy and saturating drop counter next-state.
    always_comb begin
        level_nxt_s = level_r;
        drop_nxt_s  = drop_cnt_r;
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + LW'(1);
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - LW'(1);
        end else begin
            level_nxt_s = level_r;
        end
        if (drop_s && (drop_cnt_r != {DROP_W{1'b1}})) begin
            drop_nxt_s = drop_cnt_r + DROP_W'(1);
        end else begin
            drop_nxt_s = drop_cnt_r;
        end
    end

    // Wrap tracking, pointers, occupancy and drop counter.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            prev_cnt_r <= {CNT_W{1'b0}};
            epoch_r    <= 1'b0;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            drop_cnt_r <= {DROP_W{1'b0}};
        end else begin
            prev_cnt_r <= cnt_in;
            epoch_r    <= cur_epoch_s;
            level_r    <= level_nxt_s;
            drop_cnt_r <= drop_nxt_s;
            // DEPTH is a power of two, so natural pointer overflow is modulo DEPTH.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cur_epoch_s, cnt_in};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Show-ahead head, forced to 0 while empty so stale storage never leaks out.
    always_comb begin
        head_s = {(CNT_W+1){1'b0}};
        if (empty_s) begin
            head_s = {(CNT_W+1){1'b0}};
        end else begin
            head_s = mem_r[rd_ptr_r];
        end
    end

    assign out_valid = !empty_s;
    assign out_data  = head_s;
    assign level     = level_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign drop_cnt  = drop_cnt_r;

endmodule

`ifdef FORMAL
// -----------------------------------------------------------------------------
// cnt_snapshot_fifo_chk
//   Property checker bound into cnt_snapshot_fifo.
// -----------------------------------------------------------------------------
module cnt_snapshot_fifo_chk #(
    parameter int CNT_W  = 6,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8,
    parameter int LW     = 3
) (
    input logic              clk,
    input logic              rstf,
    input logic [LW-1:0]     level,
    input logic              out_valid,
    input logic              out_ready,
    input logic [CNT_W:0]    out_data,
    input logic              empty,
    input logic [DROP_W-1:0] drop_cnt,
    input logic              push,
    input logic              pop
);

    a_level_bound: assert property (@(posedge clk) disable iff (!rstf)
        level <= LW'(DEPTH));

    a_valid_empty: assert property (@(posedge clk) disable iff (!rstf)
        out_valid == !empty);

    a_backpressure: assert property (@(posedge clk) disable iff (!rstf)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

    a_drop_mono: assert property (@(posedge clk) disable iff (!rstf)
        1'b1 |=> (drop_cnt >= $past(drop_cnt)));

    a_push_kept: assert property (@(posedge clk) disable iff (!rstf)
        (push && !pop) |=> (level == $past(level) + LW'(1)));

endmodule

bind cnt_snapshot_fifo cnt_snapshot_fifo_chk #(
    .CNT_W (CNT_W),
    .DEPTH (DEPTH),
    .DROP_W(DROP_W),
    .LW    (LW)
) u_chk (
    .clk      (clk),
    .rstf     (rstf),
    .level    (level_r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .empty    (empty_s),
    .drop_cnt (drop_cnt_r),
    .push     (push_s),
    .pop      (pop_s)
);
`endif

// File: tb/tb_cnt_snapshot_fifo.sv
// -----------------------------------------------------------------------------
// tb_cnt_snapshot_fifo
//   Directed test of cnt_snapshot_fifo with hand-computed expected values.
//   Inputs change 1 time unit after each rising edge; outputs are checked
//   at that same point, i.e. they reflect the state after the edge.
// -----------------------------------------------------------------------------
module tb_cnt_snapshot_fifo;

    logic       clk;
    logic       rstf;
    logic [5:0] cnt_in;
    logic       sample_req;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_data;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic [7:0] drop_cnt;

    int n_cmp;
    int n_err;

    cnt_snapshot_fifo #(
        .CNT_W   (6),
        .WRAP_VAL(15),
        .DEPTH   (4),
        .DROP_W  (8)
    ) dut (
        .clk       (clk),
        .rstf      (rstf),
        .cnt_in    (cnt_in),
        .sample_req(sample_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus, then advance past the next edge.
    task automatic drive(input logic [5:0] c, input logic req, input logic rdy);
        cnt_in     = c;
        sample_req = req;
        out_ready  = rdy;
        tick();
    endtask

    logic [6:0] drain_exp [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstf       = 1'b0;
        cnt_in     = 6'd0;
        sample_req = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        rstf = 1'b1;

        // Idle five cycles after reset.
        for (int i = 0; i < 5; i++) drive(6'd0, 1'b0, 1'b0);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_empty", {31'd0, empty}, 32'd1);
        check_eq("rst_level", {29'd0, level}, 32'd0);
        check_eq("rst_drop", {24'd0, drop_cnt}, 32'd0);
        check_eq("rst_full", {31'd0, full}, 32'd0);
        check_eq("rst_data", {25'd0, out_data}, 32'd0);

        // Single capture at count 3 with backpressure.
        drive(6'd1, 1'b0, 1'b0);
        drive(6'd2, 1'b0, 1'b0);
        drive(6'd3, 1'b1, 1'b0);
        check_eq("cap3_valid", {31'd0, out_valid}, 32'd1);
        check_eq("cap3_data", {25'd0, out_data}, 32'h03);
        check_eq("cap3_level", {29'd0, level}, 32'd1);
        drive(6'd4, 1'b0, 1'b0);
        check_eq("cap3_hold", {25'd0, out_data}, 32'h03);
        drive(6'd5, 1'b0, 1'b1);
        check_eq("cap3_popped", {31'd0, empty}, 32'd1);

        // Capture across the 15 -> 0 wrap.
        for (int c = 6; c < 15; c++) drive(6'(c), 1'b0, 1'b1);
        drive(6'd15, 1'b1, 1'b1);
        check_eq("wrap_pre", {25'd0, out_data}, 32'h0F);
        drive(6'd0, 1'b1, 1'b1);
        check_eq("wrap_post", {25'd0, out_data}, 32'h40);
        check_eq("wrap_level", {29'd0, level}, 32'd1);
        drive(6'd1, 1'b0, 1'b1);
        check_eq("wrap_drained", {31'd0, empty}, 32'd1);

        // Overfill: six requests at 4..9, out_ready low.
        drive(6'd2, 1'b0, 1'b0);
        drive(6'd3, 1'b0, 1'b0);
        for (int c = 4; c < 10; c++) drive(6'(c), 1'b1, 1'b0);
        check_eq("ovf_level", {29'd0, level}, 32'd4);
        check_eq("ovf_full", {31'd0, full}, 32'd1);
        check_eq("ovf_drop", {24'd0, drop_cnt}, 32'd2);
        check_eq("ovf_head", {25'd0, out_data}, 32'h44);

        // Full with simultaneous request and pop at 10.
        drive(6'd10, 1'b1, 1'b1);
        check_eq("simul_level", {29'd0, level}, 32'd4);
        check_eq("simul_drop", {24'd0, drop_cnt}, 32'd2);
        check_eq("simul_head", {25'd0, out_data}, 32'h45);

        // Drain: remaining entries in order.
        drain_exp[0] = 7'h45;
        drain_exp[1] = 7'h46;
        drain_exp[2] = 7'h47;
        drain_exp[3] = 7'h4A;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain%0d", i), {25'd0, out_data}, {25'd0, drain_exp[i]});
            drive(6'(11 + i), 1'b0, 1'b1);
        end
        check_eq("drain_empty", {31'd0, empty}, 32'd1);
        check_eq("drain_valid", {31'd0, out_valid}, 32'd0);

        // Three entries in epoch 1, then reset mid-cycle.
        drive(6'd5, 1'b1, 1'b0);
        drive(6'd6, 1'b1, 1'b0);
        drive(6'd7, 1'b1, 1'b0);
        check_eq("pre_rst_level", {29'd0, level}, 32'd3);
        check_eq("pre_rst_head", {25'd0, out_data}, 32'h45);
        sample_req = 1'b0;
        #2;
        rstf = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_level", {29'd0, level}, 32'd0);
        check_eq("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
        check_eq("mid_rst_empty", {31'd0, empty}, 32'd1);
        tick();
        rstf = 1'b1;
        drive(6'd8, 1'b1, 1'b0);
        check_eq("post_rst_data", {25'd0, out_data}, 32'h08);
        check_eq("post_rst_level", {29'd0, level}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
